// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage core: one packed bundle plus valid,
// ready/valid handshake, flush-to-bubble, and an optional 2-entry skid buffer.
module pipe_stage_reg #(
   parameter int                DATA_W     = 32*5+5,
   parameter bit                SKID       = 1'b0,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ
);

   logic accept;
   logic consume;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   generate
      if (SKID == 1'b0) begin : g_single
         logic              vld_q;
         logic [DATA_W-1:0] data_q;

         // A stalled-but-full register can still take a new bundle when the old one leaves.
         assign in_ready = out_ready | ~vld_q;

         always_ff @(posedge clk) begin
            if (!reset || flush) begin
               vld_q  <= 1'b0;
               data_q <= BUBBLE_VAL;
            end else if (accept) begin
               vld_q  <= 1'b1;
               data_q <= in_data;
            end else if (consume) begin
               vld_q  <= 1'b0;
               data_q <= BUBBLE_VAL;
            end
         end

         assign out_valid = vld_q;
         assign out_data  = data_q;
         assign occ       = {1'b0, vld_q};
      end else begin : g_skid
         typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            TWO   = 2'd2
         } state_t;

         state_t            state;
         state_t            state_nxt;
         logic [DATA_W-1:0] main_q;
         logic [DATA_W-1:0] main_nxt;
         logic [DATA_W-1:0] skid_q;
         logic [DATA_W-1:0] skid_nxt;
         logic              rdy_q;

         // in_ready is derived from the next state so it is a plain flop, not a comb path.
         always_ff @(posedge clk) begin
            if (!reset) begin
               state  <= EMPTY;
               main_q <= BUBBLE_VAL;
               skid_q <= BUBBLE_VAL;
               rdy_q  <= 1'b1;
            end else begin
               state  <= state_nxt;
               main_q <= main_nxt;
               skid_q <= skid_nxt;
               rdy_q  <= (state_nxt != TWO);
            end
         end

         always_comb begin
            state_nxt = state;
            main_nxt  = main_q;
            skid_nxt  = skid_q;
            if (flush) begin
               state_nxt = EMPTY;
               main_nxt  = BUBBLE_VAL;
               skid_nxt  = BUBBLE_VAL;
            end else begin
               case (state)
                  EMPTY: begin
                     if (accept) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                     end
                  end
                  ONE: begin
                     case ({accept, consume})
                        2'b10: begin
                           state_nxt = TWO;
                           skid_nxt  = in_data;
                        end
                        2'b01: begin
                           state_nxt = EMPTY;
                           main_nxt  = BUBBLE_VAL;
                        end
                        2'b11: main_nxt = in_data;
                        default: ;
                     endcase
                  end
                  TWO: begin
                     if (consume) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE_VAL;
                     end
                  end
                  default: begin
                     state_nxt = EMPTY;
                     main_nxt  = BUBBLE_VAL;
                     skid_nxt  = BUBBLE_VAL;
                  end
               endcase
            end
         end

         assign in_ready  = rdy_q;
         assign out_valid = (state != EMPTY);
         assign out_data  = main_q;
         assign occ       = state;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: both SKID variants share stimulus and are scored against
// bounded FIFO queue models (capacity 1 and 2).
module tb_pipe_stage_reg;
   localparam int          W    = 32*5+5;
   localparam logic [W-1:0] BUB0 = '0;
   localparam logic [W-1:0] BUB1 = W'(20'h1F00D);

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         rdy0, ov0, rdy1, ov1;
   logic [W-1:0] od0, od1;
   logic [1:0]   occ0, occ1;
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .BUBBLE_VAL(BUB0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
      .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occ(occ0));

   pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .BUBBLE_VAL(BUB1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occ(occ1));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("ov0",  W'(ov0),  W'(q0.size() != 0));
      chk("od0",  od0,      (q0.size() != 0) ? q0[0] : BUB0);
      chk("occ0", W'(occ0), W'(q0.size()));
      chk("rdy0", W'(rdy0), W'(out_ready || q0.size() == 0));
      chk("ov1",  W'(ov1),  W'(q1.size() != 0));
      chk("od1",  od1,      (q1.size() != 0) ? q1[0] : BUB1);
      chk("occ1", W'(occ1), W'(q1.size()));
      chk("rdy1", W'(rdy1), W'(q1.size() < 2));
   endtask

   // Inputs are set at the falling edge; check, then let the model follow the rising edge.
   task automatic tick();
      bit a0, a1, c0, c1;
      #1;
      check_all();
      c0 = out_ready && q0.size() != 0;
      a0 = in_valid && (out_ready || q0.size() == 0);
      c1 = out_ready && q1.size() != 0;
      a1 = in_valid && q1.size() < 2;
      @(posedge clk);
      if (!reset || flush) begin
         q0.delete();
         q1.delete();
      end else begin
         if (c0) void'(q0.pop_front());
         if (a0) q0.push_back(in_data);
         if (c1) void'(q1.pop_front());
         if (a1) q1.push_back(in_data);
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // reset held two cycles while upstream offers a bundle
      reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = W'(16'h1234);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_all();
      tick();
      reset    = 1'b1;
      in_valid = 1'b0;

      // back-to-back stream with downstream always ready
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();

      // stalled downstream fills the skid, third bundle refused, then drains in order
      out_ready = 1'b0;
      push(W'(4'hA));
      push(W'(4'hB));
      push(W'(4'hC));
      out_ready = 1'b1;
      repeat (3) tick();

      // flush at full occupancy drops held entries and the same-cycle offer
      out_ready = 1'b0;
      push(W'(8'h11));
      push(W'(8'h12));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = W'(4'hD);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();

      // accept and consume in the same cycle at occupancy one
      push(W'(4'h5));
      in_valid  = 1'b1;
      in_data   = W'(4'h6);
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      tick();

      // reset and flush while stalled at occupancy two
      out_ready = 1'b0;
      push(W'(8'h21));
      push(W'(8'h22));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      push(W'(8'h31));
      push(W'(8'h32));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         reset     = ($urandom_range(0, 63) != 0);
         in_data   = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
         tick();
      end
      reset = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
